i2c_slave: RTL
==============

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 The block SHALL have parameter SLAVE_ADDR, default 7'h50, giving the 7-bit address the slave responds to.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of flip-flop synchronizer stages on scl and sda (legal range 2-3).
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port scl, input, 1 bit: bus clock from the master.
REQ-006 The block SHALL have port sda, inout, 1 bit: bus data; the slave drives only 0 (open-drain), otherwise 1'bz.
REQ-007 The block SHALL have port sda_oe, output, 1 bit: 1 while the slave pulls sda low.
REQ-008 The block SHALL have port rx_data, output, 8 bits: last byte written by the master.
REQ-009 The block SHALL have port rx_valid, output, 1 bit: one-clk pulse when rx_data updates.
REQ-010 The block SHALL have port tx_data, input, 8 bits: byte to return on a read.
REQ-011 The block SHALL have port tx_ack, output, 1 bit: one-clk pulse when tx_data is latched; user presents the next byte before the following tx_ack.
REQ-012 The block SHALL have port rw, output, 1 bit: R/W bit of the current addressed transfer (1 = read).
REQ-013 The block SHALL have port busy, output, 1 bit: 1 from address match until stop or until an unmatched start.
REQ-014 The block SHALL have port stop_det, output, 1 bit: one-clk pulse on every detected STOP.

Function
REQ-015 scl and sda SHALL each pass through SYNC_STAGES flops; all detection SHALL use the synchronized copies (scl_s, sda_s) and their one-clk-delayed versions.
REQ-016 Rise point = scl_s 1 and previous 0; fall point = scl_s 0 and previous 1.
REQ-017 START SHALL be sda_s falling while scl_s is 1; STOP SHALL be sda_s rising while scl_s is 1.
REQ-018 States SHALL be IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
REQ-019 START in any state SHALL go to ADDR, clear the bit counter and release sda (repeated start supported).
REQ-020 STOP in any state SHALL go to IDLE, release sda, clear busy and pulse stop_det.
REQ-021 ADDR: shift sda_s MSB-first at each rise point; after the 8th bit, compare [7:1] with SLAVE_ADDR.
REQ-022 On address match, the block SHALL latch rw from bit 0, set busy and go to ADDR_ACK; on mismatch it SHALL go to WAIT_STOP with sda never driven.
REQ-023 ACK drive: assert sda_oe at the fall point after the 8th bit, hold it through the next rise point, and release it at the following fall point.
REQ-024 ADDR_ACK exit: with rw=0, go to RX; with rw=1, latch tx_data, pulse tx_ack and go to TX, driving bit 7 at the releasing fall point.
REQ-025 RX: shift 8 bits at rise points; in the clk after the 8th sample, update rx_data, pulse rx_valid and go to RX_ACK.
REQ-026 RX_ACK: the slave SHALL always ACK a written byte, then return to RX.
REQ-027 TX: update sda_oe at each fall point (sda_oe = ~bit) MSB-first; after the 8th bit's fall point, release sda and go to TX_ACK.
REQ-028 TX_ACK: sample sda_s at the rise point.
REQ-029 In TX_ACK, a master ACK (0) SHALL latch tx_data, pulse tx_ack and return to TX; a NACK (1) SHALL go to WAIT_STOP.
REQ-030 WAIT_STOP SHALL ignore all bits and leave only on START or STOP.
REQ-031 The bit counter SHALL be 3 bits; it wraps 7 to 0 only on byte completion.
REQ-032 rx_valid, tx_ack and stop_det SHALL never assert in the same clk.
REQ-033 SDA SHALL never change while scl_s is 1 except via START/STOP handling.

Reset
REQ-034 On reset low, the block SHALL immediately enter IDLE.
REQ-035 On reset low, the block SHALL set sda_oe=0, rx_data=8'h00, rx_valid=0, tx_ack=0, rw=0, busy=0 and stop_det=0.
REQ-036 On reset low, the synchronizers SHALL be set to 1 and the shift register and counter cleared.
REQ-037 Reset mid-transfer SHALL release sda at once; after reset release the block SHALL ignore the bus until the next START.

Verification
REQ-038 Write: START, 0xA0, 0xA5, STOP -> ACK on both bytes, rx_valid once with rx_data=0xA5, rw=0, stop_det once.
REQ-039 Mismatch: START, 0xA2, 0x11, STOP -> sda_oe never 1, no rx_valid, busy stays 0, stop_det pulses.
REQ-040 Read: START, 0xA1; tx_data=0x3C then 0xC3; master ACK then NACK, STOP -> bytes 0x3C and 0xC3 on sda, tx_ack twice, rw=1, IDLE after STOP.
REQ-041 Repeated start: START, 0xA0, 0x01, START, 0xA1, read 1 byte, NACK, STOP -> rx_data=0x01, then tx byte sent, rw switches 0 to 1.
REQ-042 STOP after 4 data bits of a write -> no rx_valid, state IDLE, sda_oe=0.
REQ-043 Reset while driving an ACK -> sda_oe=0 within the same clk, all outputs at reset values, next START/0xA0 ACKed normally.

Source files
------------

// File: rtl/i2c_slave.sv
// I2C slave: 7-bit addressed, byte write (rx) and byte read (tx) with repeated-start support.
// Latency: bus lines pass SYNC_STAGES flops plus one edge-detect flop; outputs are registered.
// Backpressure: none; clock stretching is not supported. The user presents the next tx byte before the following tx_ack.
//
// Ports:
//   clk       system clock, all state changes on its rising edge
//   reset     asynchronous active-low reset
//   scl       bus clock from the master
//   sda       open-drain bus data; driven only to 0, otherwise 1'bz
//   sda_oe    1 while the slave pulls sda low
//   rx_data   last byte written by the master; rx_valid pulses when it updates
//   tx_data   byte to return on a read; tx_ack pulses when it is latched
//   rw        R/W bit of the current addressed transfer (1 = read)
//   busy      1 from address match until STOP or an unmatched START
//   stop_det  one-clk pulse on every detected STOP
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ack,
  output logic       rw,
  output logic       busy,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_p_q, sda_p_q;
  logic                   scl_s, sda_s;

  logic [7:0] sh_q, sh_d;
  logic [2:0] cnt_q, cnt_d;
  // Sub-phase flag: in ACK states marks "ACK already driven"; in RX marks a
  // completed byte awaiting hand-off; in TX_ACK marks "master ACKed".
  logic       phase_q, phase_d;
  logic       oe_q, oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_ack_q, tx_ack_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       stop_det_q, stop_det_d;

  logic rise, fall, start_c, stop_c;

  assign sda = oe_q ? 1'b0 : 1'bz;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Synchronizers reset to 1 (idle bus) so reset release never fakes an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_p_q    <= scl_s;
      sda_p_q    <= sda_s;
    end
  end

  assign rise    = scl_s & ~scl_p_q;
  assign fall    = ~scl_s & scl_p_q;
  // Requiring scl high on both samples keeps a simultaneous scl/sda change
  // from being mistaken for START/STOP.
  assign start_c = scl_s & scl_p_q & sda_p_q & ~sda_s;
  assign stop_c  = scl_s & scl_p_q & ~sda_p_q & sda_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sh_q       <= 8'h00;
      cnt_q      <= 3'd0;
      phase_q    <= 1'b0;
      oe_q       <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_ack_q   <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      stop_det_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      oe_q       <= oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ack_q   <= tx_ack_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      stop_det_q <= stop_det_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    oe_d       = oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_ack_d   = 1'b0;
    rw_d       = rw_q;
    busy_d     = busy_q;
    stop_det_d = 1'b0;

    if (stop_c) begin
      state_d    = IDLE;
      oe_d       = 1'b0;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
      phase_d    = 1'b0;
      cnt_d      = 3'd0;
    end else if (start_c) begin
      state_d = ADDR;
      oe_d    = 1'b0;
      phase_d = 1'b0;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (rise) begin
            sh_d = {sh_q[6:0], sda_s};
            if (cnt_q == 3'd7) begin
              cnt_d = 3'd0;
              // sh_q[6:0] holds the seven address bits; sda_s is R/W.
              if (sh_q[6:0] == SLAVE_ADDR) begin
                rw_d    = sda_s;
                busy_d  = 1'b1;
                state_d = ADDR_ACK;
              end else begin
                busy_d  = 1'b0;
                state_d = WAIT_STOP;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        ADDR_ACK: begin
          if (fall) begin
            if (!phase_q) begin
              oe_d    = 1'b1;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              cnt_d   = 3'd0;
              if (rw_q) begin
                sh_d     = tx_data;
                tx_ack_d = 1'b1;
                oe_d     = ~tx_data[7];
                state_d  = TX;
              end else begin
                oe_d    = 1'b0;
                state_d = RX;
              end
            end
          end
        end
        RX: begin
          if (phase_q) begin
            rx_data_d  = sh_q;
            rx_valid_d = 1'b1;
            phase_d    = 1'b0;
            state_d    = RX_ACK;
          end else if (rise) begin
            sh_d = {sh_q[6:0], sda_s};
            if (cnt_q == 3'd7) begin
              cnt_d   = 3'd0;
              phase_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        RX_ACK: begin
          if (fall) begin
            if (!phase_q) begin
              oe_d    = 1'b1;
              phase_d = 1'b1;
            end else begin
              oe_d    = 1'b0;
              phase_d = 1'b0;
              state_d = RX;
            end
          end
        end
        TX: begin
          // Bit 7 was already placed on entry; each fall presents the next bit.
          if (fall) begin
            if (cnt_q == 3'd7) begin
              oe_d    = 1'b0;
              cnt_d   = 3'd0;
              state_d = TX_ACK;
            end else begin
              oe_d  = ~sh_q[6];
              sh_d  = {sh_q[6:0], 1'b0};
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        TX_ACK: begin
          if (rise && !phase_q) begin
            if (!sda_s) begin
              sh_d     = tx_data;
              tx_ack_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              state_d = WAIT_STOP;
            end
          end else if (fall && phase_q) begin
            // Drive the new byte's MSB only once scl is low again.
            oe_d    = ~sh_q[7];
            phase_d = 1'b0;
            cnt_d   = 3'd0;
            state_d = TX;
          end
        end
        WAIT_STOP: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign sda_oe   = oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ack   = tx_ack_q;
  assign rw       = rw_q;
  assign busy     = busy_q;
  assign stop_det = stop_det_q;

endmodule
